// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state/forward-select types and default zero register for the pipeline sequencer
package pipe_ctrl_pkg;
  typedef enum logic {RUN, WAIT} state_t;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10} fwd_sel_t;
  localparam int ZERO_REG = 31;
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: combinational ALU operand forwarding selects for both EX operands
module fwd_unit #(
  parameter int REG_W = 5,
  parameter int ZERO_REG = 31
)(
  input  logic [REG_W-1:0] ex_ra,
  input  logic [REG_W-1:0] ex_rb,
  input  logic [REG_W-1:0] mem_rw,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] wb_rw,
  input  logic             wb_regwrite,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);
  import pipe_ctrl_pkg::*;
  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);
  function automatic fwd_sel_t sel(input logic [REG_W-1:0] src);
    return (mem_regwrite && mem_rw != ZR && mem_rw == src) ? FWD_EXMEM :
           (wb_regwrite && wb_rw != ZR && wb_rw == src) ? FWD_MEMWB : FWD_RF;
  endfunction
  // EX/MEM result is newer than MEM/WB, so it is checked first
  always_comb begin
    fwd_a = sel(ex_ra);
    fwd_b = sel(ex_rb);
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: five-stage pipeline stall/flush/forward sequencer with dmem wait FSM; PIPE_HAZARD_PERF_EN adds perf counters
module pipe_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int ZERO_REG = pipe_ctrl_pkg::ZERO_REG,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W = 32
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_ra,
  input  logic [REG_W-1:0] id_rb,
  input  logic             id_uses_rb,
  input  logic [REG_W-1:0] ex_rw,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic [REG_W-1:0] ex_ra,
  input  logic [REG_W-1:0] ex_rb,
  input  logic [REG_W-1:0] mem_rw,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic             mem_memwrite,
  input  logic [REG_W-1:0] wb_rw,
  input  logic             wb_regwrite,
  input  logic             br_taken,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             pc_sel_br,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             dmem_timeout
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_wait_cnt
`endif
);
  import pipe_ctrl_pkg::*;
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);
  state_t state;
  logic [CW-1:0] cnt;
  logic load_use, to_hit, frz, run, br, stall;
  logic [1:0] fa, fb;
  logic unused_ex_regwrite;
  // ex_regwrite is part of the ID/EX bundle but load-use only needs ex_memread
  assign unused_ex_regwrite = ex_regwrite;
  fwd_unit #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_fwd (
    .ex_ra(ex_ra), .ex_rb(ex_rb), .mem_rw(mem_rw), .mem_regwrite(mem_regwrite),
    .wb_rw(wb_rw), .wb_regwrite(wb_regwrite), .fwd_a(fa), .fwd_b(fb)
  );
  // priority: memory freeze, timeout release, branch flush, load-use bubble, free run
  always_comb begin
    dmem_req = (mem_memread | mem_memwrite) & ~reset;
    load_use = ex_memread & (ex_rw != ZR) & ((ex_rw == id_ra) | (id_uses_rb & (ex_rw == id_rb)));
    to_hit = (state == WAIT) & ~dmem_ready & (cnt == MAX_C);
    frz = ~reset & ((state == RUN) ? dmem_req & ~dmem_ready : ~dmem_ready & ~to_hit);
    run = ~reset & ~frz & ~to_hit;
    br = run & br_taken;
    stall = run & ~br_taken & load_use;
    pc_we = ~reset & ~frz & ~stall;
    if_id_we = pc_we;
    id_ex_we = ~reset & ~frz;
    ex_mem_we = id_ex_we;
    mem_wb_we = id_ex_we;
    pc_sel_br = br;
    if_id_flush = br;
    id_ex_flush = br | stall;
    ex_mem_flush = br;
    fwd_a = reset ? FWD_RF : fa;
    fwd_b = reset ? FWD_RF : fb;
  end
  // wait FSM: counter starts at 1 on the freezing cycle and forces release at MAX_WAIT
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt <= '0;
      dmem_timeout <= 1'b0;
    end else if (state == RUN) begin
      if (dmem_req & ~dmem_ready) begin
        state <= WAIT;
        cnt <= CW'(1);
      end
    end else if (dmem_ready | to_hit) begin
      state <= RUN;
      cnt <= '0;
      dmem_timeout <= dmem_timeout | to_hit;
    end else
      cnt <= (cnt == MAX_C) ? cnt : cnt + CW'(1);
  end
`ifdef PIPE_HAZARD_PERF_EN
  // free-running event counters, wrapping naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_wait_cnt <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + CNT_W'(stall);
      perf_flush_cnt <= perf_flush_cnt + CNT_W'(br);
      perf_wait_cnt <= perf_wait_cnt + CNT_W'(state == WAIT);
    end
  end
`endif
endmodule
